kanagawa_fifo_debug_monitor: RTL and testbench
==============================================

// Module: kanagawa_fifo_debug_monitor
//
// PURPOSE
// Single-clock FIFO misuse monitor, attached beside any single-clock FIFO.
// - Samples the FIFO's write/read strobes against its full/empty status every cycle.
// - Latches sticky overflow (write while full) and underflow (read while empty) flags.
// - Keeps saturating counts of each event for debug readout.
// - Pure observer: never drives or gates the FIFO.
//
// PARAMETERS
// COUNT_WIDTH  16  width of each saturating event counter (>=1)
// SIM_REPORT   0   1: emit $error in simulation on each offending cycle; 0: silent
//
// PORTS
// clk                  in   1            clock; all state updates on rising edge
// rst                  in   1            reset, asynchronous, active-low (0 = in reset)
// full_in              in   1            FIFO full status
// wren_in              in   1            FIFO write strobe
// empty_in             in   1            FIFO empty status
// rden_in              in   1            FIFO read strobe
// clear_in             in   1            synchronous clear of flags and counters
// overflow_out         out  1            sticky: a write while full has been seen
// underflow_out        out  1            sticky: a read while empty has been seen
// overflow_count_out   out  COUNT_WIDTH  number of overflow cycles, saturating
// underflow_count_out  out  COUNT_WIDTH  number of underflow cycles, saturating
//
// BEHAVIOUR
// - Reset (rst==0, async): all outputs 0 immediately and while held.
//   Release takes effect at the next clk edge.
// - ovf_evt = wren_in & full_in; unf_evt = rden_in & empty_in; sampled each rising edge.
// - Latency: an event sampled at edge N makes the flag 1 (and the count +1) after edge N.
//   The change is visible from edge N to edge N+1.
// - Flags are sticky: once 1, they stay 1 until reset or clear_in.
//   Later non-event cycles do not clear them.
// - wren_in without full_in, and rden_in without empty_in: no effect.
//   full_in or empty_in alone: no effect.
// - Overflow and underflow paths are fully independent; both may set in the same cycle.
// - Counters: +1 per event cycle; hold at 2^COUNT_WIDTH-1, no wrap.
// - clear_in=1 at an edge: flags and counters go to 0.
//   clear_in has priority over an event in the same cycle, so that event is lost.
// - Reset mid-operation: async clear wins over any pending event.
// - Inputs are assumed synchronous to clk; no input synchronisers.
// - SIM_REPORT=1: $error once per offending cycle, excluded from synthesis.
//
// TESTING
// 1. Hold rst=0 for 50 cycles, then release.
//    -> overflow_out=0, underflow_out=0, both counts 0.
// 2. wren_in=1, full_in=0 for 1 cycle.
//    -> overflow_out=0, underflow_out=0 after the next edge.
// 3. wren_in=1, full_in=1 for 1 cycle, then both 0.
//    -> overflow_out=1, overflow_count_out=1, underflow_out=0; flag stays 1 for 10 idle cycles.
// 4. rden_in=1 with empty_in=0, then rden_in=1 with empty_in=1.
//    -> underflow_out 0 then 1; overflow_out remains 1.
// 5. Pulse rst=0 for 1 cycle (and separately clear_in=1).
//    -> all flags and counts 0; with clear_in and an event in the same cycle -> still 0.
// 6. COUNT_WIDTH=2; 5 consecutive overflow cycles.
//    -> overflow_count_out saturates at 3.

Source files
------------

// File: rtl/kanagawa_fifo_debug_monitor.sv
// FIFO misuse monitor: watches write-while-full and read-while-empty on a single-clock FIFO,
// keeping sticky flags and saturating event counts. Never drives the FIFO itself.
module kanagawa_fifo_debug_monitor #(
    parameter int COUNT_WIDTH = 16,
    parameter bit SIM_REPORT  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   full_in,
    input  logic                   wren_in,
    input  logic                   empty_in,
    input  logic                   rden_in,
    input  logic                   clear_in,
    output logic                   overflow_out,
    output logic                   underflow_out,
    output logic [COUNT_WIDTH-1:0] overflow_count_out,
    output logic [COUNT_WIDTH-1:0] underflow_count_out
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        if (&value) begin
            return value;
        end
        return value + CNT_ONE;
    endfunction

    logic                   ovf_evt;
    logic                   unf_evt;
    logic                   ovf_flag_p0;
    logic                   unf_flag_p0;
    logic [COUNT_WIDTH-1:0] ovf_cnt_p0;
    logic [COUNT_WIDTH-1:0] unf_cnt_p0;

    assign ovf_evt = wren_in & full_in;
    assign unf_evt = rden_in & empty_in;

    // Event sample -> flag/count register; clear outranks a same-cycle event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_flag_p0 <= 1'b0;
            unf_flag_p0 <= 1'b0;
            ovf_cnt_p0  <= '0;
            unf_cnt_p0  <= '0;
        end else if (clear_in) begin
            ovf_flag_p0 <= 1'b0;
            unf_flag_p0 <= 1'b0;
            ovf_cnt_p0  <= '0;
            unf_cnt_p0  <= '0;
        end else begin
            if (ovf_evt) begin
                ovf_flag_p0 <= 1'b1;
                ovf_cnt_p0  <= sat_inc(ovf_cnt_p0);
            end
            if (unf_evt) begin
                unf_flag_p0 <= 1'b1;
                unf_cnt_p0  <= sat_inc(unf_cnt_p0);
            end
        end
    end

    assign overflow_out        = ovf_flag_p0;
    assign underflow_out       = unf_flag_p0;
    assign overflow_count_out  = ovf_cnt_p0;
    assign underflow_count_out = unf_cnt_p0;

`ifndef SYNTHESIS
    generate
        if (SIM_REPORT) begin : g_sim_report
            always @(posedge clk) begin
                if (rst && ovf_evt) begin
                    $error("kanagawa_fifo_debug_monitor: write while full");
                end
                if (rst && unf_evt) begin
                    $error("kanagawa_fifo_debug_monitor: read while empty");
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_kanagawa_fifo_debug_monitor.sv
// Directed bench for kanagawa_fifo_debug_monitor: a 16-bit instance for flag/count behaviour
// and a 2-bit instance sharing the same inputs for counter saturation.
module tb_kanagawa_fifo_debug_monitor;

    logic        clk;
    logic        rst;
    logic        full_in;
    logic        wren_in;
    logic        empty_in;
    logic        rden_in;
    logic        clear_in;
    logic        overflow_out;
    logic        underflow_out;
    logic [15:0] overflow_count_out;
    logic [15:0] underflow_count_out;
    logic        sm_overflow_out;
    logic        sm_underflow_out;
    logic [1:0]  sm_overflow_count_out;
    logic [1:0]  sm_underflow_count_out;

    int n_checks = 0;
    int n_fail   = 0;

    kanagawa_fifo_debug_monitor #(.COUNT_WIDTH(16), .SIM_REPORT(1'b0)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .full_in             (full_in),
        .wren_in             (wren_in),
        .empty_in            (empty_in),
        .rden_in             (rden_in),
        .clear_in            (clear_in),
        .overflow_out        (overflow_out),
        .underflow_out       (underflow_out),
        .overflow_count_out  (overflow_count_out),
        .underflow_count_out (underflow_count_out)
    );

    kanagawa_fifo_debug_monitor #(.COUNT_WIDTH(2), .SIM_REPORT(1'b0)) dut_small (
        .clk                 (clk),
        .rst                 (rst),
        .full_in             (full_in),
        .wren_in             (wren_in),
        .empty_in            (empty_in),
        .rden_in             (rden_in),
        .clear_in            (clear_in),
        .overflow_out        (sm_overflow_out),
        .underflow_out       (sm_underflow_out),
        .overflow_count_out  (sm_overflow_count_out),
        .underflow_count_out (sm_underflow_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        full_in  = 1'b0;
        wren_in  = 1'b0;
        empty_in = 1'b0;
        rden_in  = 1'b0;
        clear_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ovf"},  {31'd0, overflow_out},        32'd0);
        check({tag, "_unf"},  {31'd0, underflow_out},       32'd0);
        check({tag, "_ocnt"}, {16'd0, overflow_count_out},  32'd0);
        check({tag, "_ucnt"}, {16'd0, underflow_count_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Reset held for 50 cycles, with events present to show reset dominates.
        repeat (25) step();
        wren_in = 1'b1; full_in = 1'b1; rden_in = 1'b1; empty_in = 1'b1;
        repeat (25) step();
        check_all_zero("in_reset");
        idle_inputs();
        rst = 1'b1;
        step();
        check_all_zero("after_release");
        check("sm_ocnt_reset", {30'd0, sm_overflow_count_out}, 32'd0);

        // Write without full, and full without write: no effect.
        wren_in = 1'b1;
        step();
        wren_in = 1'b0; full_in = 1'b1;
        step();
        full_in = 1'b0; rden_in = 1'b1;
        step();
        rden_in = 1'b0; empty_in = 1'b1;
        step();
        empty_in = 1'b0;
        check_all_zero("no_event");

        // Single overflow cycle, flag must stick through idle cycles.
        wren_in = 1'b1; full_in = 1'b1;
        step();
        idle_inputs();
        check("ovf_set",   {31'd0, overflow_out},        32'd1);
        check("ocnt_one",  {16'd0, overflow_count_out},  32'd1);
        check("unf_quiet", {31'd0, underflow_out},       32'd0);
        repeat (10) step();
        check("ovf_sticky",  {31'd0, overflow_out},       32'd1);
        check("ocnt_sticky", {16'd0, overflow_count_out}, 32'd1);

        // Read while not empty, then read while empty.
        rden_in = 1'b1; empty_in = 1'b0;
        step();
        check("unf_not_empty", {31'd0, underflow_out}, 32'd0);
        empty_in = 1'b1;
        step();
        idle_inputs();
        check("unf_set",    {31'd0, underflow_out},       32'd1);
        check("ucnt_one",   {16'd0, underflow_count_out}, 32'd1);
        check("ovf_remain", {31'd0, overflow_out},        32'd1);

        // Both events in the same cycle count independently.
        wren_in = 1'b1; full_in = 1'b1; rden_in = 1'b1; empty_in = 1'b1;
        step();
        idle_inputs();
        check("both_ocnt", {16'd0, overflow_count_out},  32'd2);
        check("both_ucnt", {16'd0, underflow_count_out}, 32'd2);

        // Asynchronous reset pulse mid-operation, seen before the next edge.
        rst = 1'b0;
        #2;
        check_all_zero("async_rst");
        wren_in = 1'b1; full_in = 1'b1;
        step();
        idle_inputs();
        rst = 1'b1;
        check_all_zero("rst_pulse");

        // Clear with simultaneous events: the events are lost.
        wren_in = 1'b1; full_in = 1'b1;
        step();
        check("pre_clear_ovf", {31'd0, overflow_out}, 32'd1);
        rden_in = 1'b1; empty_in = 1'b1; clear_in = 1'b1;
        step();
        idle_inputs();
        check_all_zero("clear_evt");
        wren_in = 1'b1; full_in = 1'b1;
        step();
        idle_inputs();
        check("post_clear_ocnt", {16'd0, overflow_count_out}, 32'd1);

        // Saturation on the 2-bit instance over 5 consecutive overflow cycles.
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        check("sm_clear", {30'd0, sm_overflow_count_out}, 32'd0);
        wren_in = 1'b1; full_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("sm_ocnt_%0d", i), {30'd0, sm_overflow_count_out},
                  (i > 3) ? 32'd3 : 32'(i));
        end
        idle_inputs();
        check("wide_ocnt_5", {16'd0, overflow_count_out},  32'd5);
        check("sm_ovf_flag", {31'd0, sm_overflow_out},     32'd1);
        check("sm_unf_flag", {31'd0, sm_underflow_out},    32'd0);
        check("sm_ucnt",     {30'd0, sm_underflow_count_out}, 32'd0);
        step();
        check("sm_ocnt_hold", {30'd0, sm_overflow_count_out}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
